// File: rtl/vga_scan_driver_if.sv
// ---------------------------------------------------------------------------
// vga_scan_driver_if
// Connects the raster/pixel stage (vga_scan_driver) to the display controller
// that answers pixel queries and to the VGA connector it drives.
//
// Signals:
//   xpix[9:0]   raster -> controller  horizontal coordinate being scanned
//   ypix[9:0]   raster -> controller  vertical coordinate being scanned
//   video_on    raster -> controller  coordinate lies in the visible area
//   pixval      controller -> raster  pixel-on for the current xpix/ypix
//   altcol      controller -> raster  alternate-colour select for that pixel
//   hsync       raster -> connector   horizontal sync (aligned with rgb)
//   vsync       raster -> connector   vertical sync (aligned with rgb)
//   rgb[11:0]   raster -> connector   {R[3:0],G[3:0],B[3:0]}
//   frame_tick  raster -> game logic  one-clk pulse at start of vblank
//
// Modports:
//   master  the raster stage (drives coordinates, syncs, colour)
//   slave   the display controller / connector side
// ---------------------------------------------------------------------------
interface vga_scan_driver_if;
  logic [9:0]  xpix;
  logic [9:0]  ypix;
  logic        video_on;
  logic        pixval;
  logic        altcol;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_tick;

  modport master (
    output xpix, ypix, video_on, hsync, vsync, rgb, frame_tick,
    input  pixval, altcol
  );

  modport slave (
    input  xpix, ypix, video_on, hsync, vsync, rgb, frame_tick,
    output pixval, altcol
  );
endinterface

// File: rtl/vga_scan_driver.sv
// ---------------------------------------------------------------------------
// vga_scan_driver
// Raster timing generator and pixel output stage for the Pong display path.
// A free-running x/y scan counter advances once per pix_ce strobe. The
// coordinate is presented undelayed to the display controller, whose
// combinational pixval/altcol answer is registered one enabled cycle later
// together with the raw syncs, so rgb, hsync and vsync always describe the
// same coordinate with no relative skew.
//
// Ports:
//   clk      system clock
//   rst      synchronous reset, active-high (acts regardless of pix_ce)
//   pix_ce   pixel-rate enable; every register holds while it is low
//   bus      vga_scan_driver_if.master (xpix, ypix, video_on, pixval,
//            altcol, hsync, vsync, rgb, frame_tick)
//
// Build option:
//   VGA_BORDER_EN  when defined, the outermost ring of visible pixels is
//                  forced to COL_FG (monitor alignment aid). Blanking still
//                  wins outside the visible area.
//
// Totals above 1024 in either direction do not fit the 10-bit counters and
// are not supported.
// ---------------------------------------------------------------------------
module vga_scan_driver #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter logic [11:0] COL_FG   = 12'hFFF,
  parameter logic [11:0] COL_ALT  = 12'h555,
  parameter logic [11:0] COL_BG   = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  vga_scan_driver_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit versions of the decode points so every compare is width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // -------------------------------------------------------------------------
  // Scan counters
  // -------------------------------------------------------------------------
  logic [9:0] x_q, y_q;
  logic       x_wrap, y_wrap;

  assign x_wrap = (x_q == H_LAST);
  assign y_wrap = (y_q == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_ce) begin
      if (x_wrap) begin
        x_q <= '0;
        y_q <= y_wrap ? '0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Raw (undelayed) decode of the current coordinate
  // -------------------------------------------------------------------------
  logic video_raw, hs_raw, vs_raw;

  assign video_raw = (x_q < H_ACT) && (y_q < V_ACT);
  assign hs_raw    = (x_q >= HS_START) && (x_q < HS_END);
  assign vs_raw    = (y_q >= VS_START) && (y_q < VS_END);

`ifdef VGA_BORDER_EN
  logic border;
  assign border = (x_q == '0) || (x_q == H_ACT - 10'd1) ||
                  (y_q == '0) || (y_q == V_ACT_LAST);
`endif

  // Colour select for the coordinate currently on xpix/ypix. The controller
  // answers combinationally, so pixval/altcol belong to this same coordinate.
  logic [11:0] rgb_next;

  always_comb begin
    rgb_next = '0;
    if (!video_raw)         rgb_next = '0;   // blanking overrides everything
`ifdef VGA_BORDER_EN
    else if (border)        rgb_next = COL_FG;
`endif
    else if (!bus.pixval)   rgb_next = COL_BG;
    else if (bus.altcol)    rgb_next = COL_ALT;
    else                    rgb_next = COL_FG;
  end

  // -------------------------------------------------------------------------
  // Output stage: colour and syncs share one register so they stay aligned.
  // -------------------------------------------------------------------------
  logic [11:0] rgb_q;
  logic        hs_q, vs_q, tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      tick_q <= 1'b0;
    end else begin
      // Evaluated every clk (not only on pix_ce) so the pulse is exactly one
      // clk wide: the following clk either has pix_ce low or x no longer last.
      tick_q <= pix_ce && x_wrap && (y_q == V_ACT_LAST);
      if (pix_ce) begin
        rgb_q <= rgb_next;
        hs_q  <= hs_raw ? SYNC_POL : ~SYNC_POL;
        vs_q  <= vs_raw ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign bus.xpix       = x_q;
  assign bus.ypix       = y_q;
  assign bus.video_on   = video_raw;
  assign bus.rgb        = rgb_q;
  assign bus.hsync      = hs_q;
  assign bus.vsync      = vs_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_driver
// Scoreboard bench for vga_scan_driver. The DUT is built with a shrunken
// raster (32x17 total, 20x10 visible) so several whole frames fit in a short
// run. Hand-computed windows for that geometry:
//   hsync low for x = 24..29, vsync low for y = 12..13 (active-low syncs)
//   visible area x < 20, y < 10
//   frame_tick after the edge leaving (31,9) for (0,10)
// The driver pushes one expected observation per enabled edge; the monitor
// pops it after that edge and compares the whole observable state. Edges
// with pix_ce low must hold the previous state with frame_tick low.
// ---------------------------------------------------------------------------
module tb_vga_scan_driver;
  localparam int HA = 20, HF = 4, HS = 6, HB = 2;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = 32, VT = 17;
  localparam int FRAME = HT * VT;   // 544 enabled cycles per frame

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        tick;
    logic [9:0]  x;
    logic [9:0]  y;
  } obs_t;

  logic clk = 1'b0;
  logic rst, pix_ce;

  vga_scan_driver_if bus ();

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .COL_FG(12'hFFF), .COL_ALT(12'h555), .COL_BG(12'h000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pix_ce (pix_ce),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  obs_t  q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string phase = "init";
  int    mx = 0, my = 0;   // coordinate the DUT shows after the last edge

  localparam obs_t RST_EXP = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, vid: 1'b1,
                               tick: 1'b0, x: 10'd0, y: 10'd0};

  // Expected state after one enabled edge taken while showing (x,y).
  function automatic obs_t expect_edge(int x, int y, bit pv, bit ac);
    obs_t e;
    bit   vid;
    int   nx, ny;
    vid = (x < 20) && (y < 10);
    if (!vid)                                       e.rgb = 12'h000;
`ifdef VGA_BORDER_EN
    else if (x == 0 || x == 19 || y == 0 || y == 9) e.rgb = 12'hFFF;
`endif
    else if (!pv)                                   e.rgb = 12'h000;
    else if (ac)                                    e.rgb = 12'h555;
    else                                            e.rgb = 12'hFFF;
    e.hs   = !(x >= 24 && x <= 29);
    e.vs   = !(y >= 12 && y <= 13);
    nx     = (x == 31) ? 0 : x + 1;
    ny     = (x == 31) ? ((y == 16) ? 0 : y + 1) : y;
    e.x    = 10'(nx);
    e.y    = 10'(ny);
    e.vid  = (nx < 20) && (ny < 10);
    e.tick = (x == 31) && (y == 9);
    return e;
  endfunction

  task automatic step(input bit ce, input bit r, input bit pv, input bit ac);
    obs_t e;
    @(negedge clk);
    pix_ce     = ce;
    rst        = r;
    bus.pixval = pv;
    bus.altcol = ac;
    if (r) begin
      mx = 0;
      my = 0;
    end else if (ce) begin
      e = expect_edge(mx, my, pv, ac);
      q.push_back(e);
      mx = int'(e.x);
      my = int'(e.y);
    end
  endtask

  function automatic bit pat(int x, int y, int k);
    return ((x + y + k) % 3) == 0;
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin
    obs_t got, exp_o, last;
    bit   s_rst, s_ce;
    last = RST_EXP;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_ce  = pix_ce;
      @(negedge clk);
      got.rgb  = bus.rgb;
      got.hs   = bus.hsync;
      got.vs   = bus.vsync;
      got.vid  = bus.video_on;
      got.tick = bus.frame_tick;
      got.x    = bus.xpix;
      got.y    = bus.ypix;
      exp_o    = last;
      exp_o.tick = 1'b0;
      if (s_rst) begin
        exp_o = RST_EXP;
      end else if (s_ce) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s underflow t=%0t got enabled edge, expected no pending vector",
                   phase, $time);
        end else begin
          exp_o = q.pop_front();
        end
      end
      n_vec++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL %s t=%0t got x=%0d y=%0d vid=%b rgb=%h hs=%b vs=%b tick=%b, expected x=%0d y=%0d vid=%b rgb=%h hs=%b vs=%b tick=%b",
                 phase, $time, got.x, got.y, got.vid, got.rgb, got.hs, got.vs, got.tick,
                 exp_o.x, exp_o.y, exp_o.vid, exp_o.rgb, exp_o.hs, exp_o.vs, exp_o.tick);
      end
      last = exp_o;
    end
  end

  // --------------------------------------------------------------- watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t run did not finish, expected completion", $time);
    $fatal(1, "timeout");
  end

  // ----------------------------------------------------------------- driver
  initial begin
    rst = 1'b1; pix_ce = 1'b0; bus.pixval = 1'b0; bus.altcol = 1'b0;

    phase = "reset";
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);            // reset wins over pix_ce

    // One lit pixel at (10,5): FFF, then 555 the next frame; also covers the
    // full-frame wrap back to (0,0) after exactly FRAME enabled cycles.
    phase = "single_fg";
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, (mx == 10 && my == 5), 1'b0);
    phase = "single_alt";
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, (mx == 10 && my == 5), 1'b1);

    // pixval stuck high: blanking must still force rgb to 0.
    phase = "all_on";
    for (int i = 0; i < FRAME; i++) step(1'b1, 1'b0, 1'b1, 1'b0);

    // pix_ce every 4th clk: holds between strobes, one-clk frame_tick.
    phase = "ce_div4";
    for (int i = 0; i < FRAME * 4 + 8; i++)
      step(i % 4 == 3, 1'b0, pat(mx, my, 0), pat(mx, my, 1));

    // Reset for one clk while showing (15,6), then resume counting.
    phase = "reset_mid";
    for (int i = 0; i < FRAME && !(mx == 15 && my == 6); i++)
      step(1'b1, 1'b0, pat(mx, my, 2), 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < FRAME / 2; i++) step(1'b1, 1'b0, pat(mx, my, 1), pat(mx, my, 2));

    // Irregular enable duty cycle.
    phase = "ce_irregular";
    for (int i = 0; i < FRAME * 2; i++)
      step((i % 3 == 0) || (i % 7 == 2), 1'b0, pat(mx, my, 0), pat(mx, my, 2));

    phase = "drain";
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
